// File: rtl/hmac_param_pkg.sv
// Shared types and constants for the HMAC block sequencer.
package hmac_param_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        CMD       = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } hmac_seq_state_e;

    localparam int HMAC_SEQ_BLOCK_WORDS = 32;
    localparam int HMAC_SEQ_DATA_W      = 32;

endpackage

// File: rtl/hmac_block_sequencer_if.sv
// Message word stream between a DMA/stream requester and the sequencer.
//
// Handshake: the master holds msg_valid, msg_data and msg_last stable until
// the slave accepts; a word transfers on a rising clk edge where both
// msg_valid and msg_ready are high. msg_ready never depends on msg_valid.
interface hmac_block_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              msg_valid;
    logic              msg_ready;
    logic [DATA_W-1:0] msg_data;
    logic              msg_last;

    modport master (
        output msg_valid,
        output msg_data,
        output msg_last,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_data,
        input  msg_last,
        output msg_ready
    );
endinterface

// File: rtl/hmac_block_sequencer.sv
// Assembles a pre-padded word stream into 1024-bit blocks and drives the
// HMAC-384 core with init/next commands, pulsing done once the tag is valid.
module hmac_block_sequencer
    import hmac_param_pkg::*;
#(
    parameter int BLOCK_WORDS = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    hmac_block_sequencer_if.slave         msg,
    output logic                          core_init,
    output logic                          core_next,
    output logic [BLOCK_WORDS*DATA_W-1:0] core_block,
    input  logic                          core_ready,
    input  logic                          core_tag_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output hmac_seq_state_e               dbg_state
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_WORDS - 1);

    hmac_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              first_blk_q, first_blk_d;
    logic              last_blk_q, last_blk_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] blk_q [BLOCK_WORDS];
    logic [DATA_W-1:0] blk_d [BLOCK_WORDS];

    logic hs;
    logic at_last_word;

    assign hs           = msg.msg_valid && (state_q == FILL);
    assign at_last_word = (word_cnt_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = FILL;
            FILL: begin
                if (hs) begin
                    if (at_last_word)       state_d = CMD;
                    else if (msg.msg_last)  state_d = IDLE;
                end
            end
            CMD:       state_d = WAIT_BUSY;
            WAIT_BUSY: if (!core_ready) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (core_ready) begin
                    if (!last_blk_q)         state_d = FILL;
                    else if (core_tag_valid) state_d = DONE;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Datapath registers: word counter, block flags, sticky error, buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_q  <= '0;
            first_blk_q <= 1'b1;
            last_blk_q  <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk_q[i] <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            first_blk_q <= first_blk_d;
            last_blk_q  <= last_blk_d;
            err_q       <= err_d;
            for (int i = 0; i < BLOCK_WORDS; i++) blk_q[i] <= blk_d[i];
        end
    end

    // Datapath updates; an aborted or failed message leaves a zeroed buffer.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        first_blk_d = first_blk_q;
        last_blk_d  = last_blk_q;
        err_d       = err_q;
        for (int i = 0; i < BLOCK_WORDS; i++) blk_d[i] = blk_q[i];

        if (abort) begin
            for (int i = 0; i < BLOCK_WORDS; i++) blk_d[i] = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d       = 1'b0;
                        first_blk_d = 1'b1;
                        word_cnt_d  = '0;
                    end
                end
                FILL: begin
                    if (hs) begin
                        blk_d[word_cnt_q] = msg.msg_data;
                        word_cnt_d        = word_cnt_q + 1'b1;
                        if (at_last_word) begin
                            last_blk_d = msg.msg_last;
                        end else if (msg.msg_last) begin
                            err_d = 1'b1;
                            for (int i = 0; i < BLOCK_WORDS; i++) blk_d[i] = '0;
                        end
                    end
                end
                CMD:  first_blk_d = 1'b0;
                DONE: begin
                    for (int i = 0; i < BLOCK_WORDS; i++) blk_d[i] = '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state only, so a reset cannot leave a command high.
    always_comb begin
        msg.msg_ready = (state_q == FILL);
        core_init     = (state_q == CMD) && first_blk_q;
        core_next     = (state_q == CMD) && !first_blk_q;
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        err           = err_q;
        dbg_state     = state_q;
        core_block    = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            core_block[(BLOCK_WORDS-1-i)*DATA_W +: DATA_W] = blk_q[i];
        end
    end

    a_block_words: assert property (@(posedge clk)
        (BLOCK_WORDS == HMAC_SEQ_BLOCK_WORDS) && (DATA_W == HMAC_SEQ_DATA_W));
    a_cmd_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({core_init, core_next}));
    a_ready_fill: assert property (@(posedge clk) disable iff (!reset_n)
        msg.msg_ready |-> state_q == FILL);
    a_done_idle: assert property (@(posedge clk) disable iff (!reset_n)
        done |=> !busy);

endmodule

// File: tb/tb_hmac_block_sequencer.sv
// Bench for hmac_block_sequencer: random messages, a reactive core model,
// and a scoreboard of expected commands/blocks/done events.
module tb_hmac_block_sequencer;
    import hmac_param_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            core_init, core_next;
    logic [1023:0]   core_block;
    logic            core_ready;
    logic            core_tag_valid;
    logic            busy, done, err;
    hmac_seq_state_e dbg_state;

    hmac_block_sequencer_if mif();

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int tag_rise_cyc = 0;
    int done_cnt = 0;

    // Expected events: [1025:1024] = 01 init, 10 next, 11 done; [1023:0] block.
    logic [1025:0] exp_q[$];

    hmac_block_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .msg            (mif),
        .core_init      (core_init),
        .core_next      (core_next),
        .core_block     (core_block),
        .core_ready     (core_ready),
        .core_tag_valid (core_tag_valid),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [1025:0] act, input logic [1025:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: drops ready the cycle after a command, completes after a
    // random latency, then raises tag_valid a few cycles later.
    initial begin : core_model
        int lat, tl;
        core_ready     = 1'b1;
        core_tag_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && (core_init || core_next)) begin
                lat = $urandom_range(2, 6);
                tl  = $urandom_range(0, 3);
                @(posedge clk); #1;
                core_ready     = 1'b0;
                core_tag_valid = 1'b0;
                repeat (lat) @(posedge clk);
                #1 core_ready = 1'b1;
                repeat (tl) @(posedge clk);
                #1 core_tag_valid = 1'b1;
                tag_rise_cyc = cyc;
            end
        end
    end

    // Monitor: compares every command and done pulse against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [1025:0] e;
        if (reset_n) begin
            if (core_init || core_next) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", {core_next, core_init}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_kind", {core_next, core_init}, e[1025:1024]);
                    chk("cmd_block", core_block, e[1023:0]);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", {done, done}, e[1025:1024]);
                    chk("done_latency", cyc - tag_rise_cyc, 1);
                end
                done_cnt++;
            end
            if (mif.msg_ready) chk("ready_gap", core_ready, 1);
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic last);
        int budget;
        budget        = 0;
        mif.msg_valid = 1'b1;
        mif.msg_data  = d;
        mif.msg_last  = last;
        @(negedge clk);
        while (!mif.msg_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!mif.msg_ready) chk("ready_timeout", mif.msg_ready, 1);
        @(posedge clk); #1;
        mif.msg_valid = 1'b0;
        mif.msg_last  = 1'b0;
    endtask

    // Start pulse with the first word already offered: it must not be taken.
    task automatic do_start(input logic [31:0] w0);
        start         = 1'b1;
        mif.msg_valid = 1'b1;
        mif.msg_data  = w0;
        mif.msg_last  = 1'b0;
        @(negedge clk);
        chk("start_ready", mif.msg_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_state", dbg_state, FILL);
        chk("start_err", err, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", {core_init, core_next, busy, done, err, mif.msg_ready}, 0);
        chk("rst_block", core_block, 0);
        chk("rst_state", dbg_state, IDLE);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One message. early_at: word carrying a premature msg_last; reset_at:
    // reset after that word's handshake; abort_blk: abort in WAIT_DONE of
    // that block. Negative means unused.
    task automatic send_msg(input int nblk, input int early_at, input int reset_at,
                            input int abort_blk, input bit gaps, input bit counting);
        logic [31:0]   words[$];
        logic [1023:0] blk;
        int total, nexp, d0, budget, b;
        total = nblk * 32;
        for (int i = 0; i < total; i++) words.push_back(counting ? 32'(i) : $urandom());
        if (early_at < 0 && reset_at < 0) begin
            nexp = (abort_blk < 0) ? nblk : abort_blk + 1;
            for (int bb = 0; bb < nexp; bb++) begin
                blk = '0;
                for (int w = 0; w < 32; w++) blk[1023-32*w -: 32] = words[bb*32+w];
                exp_q.push_back({(bb == 0) ? 2'b01 : 2'b10, blk});
            end
            if (abort_blk < 0) exp_q.push_back({2'b11, 1024'b0});
        end
        d0 = done_cnt;
        do_start(words[0]);
        for (int i = 0; i < total; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                if (i == 5) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("busy_start_state", dbg_state, FILL);
                    chk("busy_start_err", err, 0);
                end
            end
            drive_word(words[i], (i == total - 1) || (i == early_at));
            if (i == reset_at) begin
                do_reset();
                return;
            end
            if (i == early_at) begin
                @(negedge clk);
                chk("early_err", err, 1);
                chk("early_state", dbg_state, IDLE);
                chk("early_block", core_block, 0);
                chk("early_cmd", {core_next, core_init}, 0);
                @(posedge clk); #1;
                return;
            end
            if (i % 32 == 31) begin
                b = i / 32;
                @(negedge clk);
                chk("cmd_latency", {core_next, core_init}, (b == 0) ? 2'b01 : 2'b10);
                chk("blk_word0", core_block[1023:992], words[i-31]);
                chk("blk_word31", core_block[31:0], words[i]);
                @(posedge clk); #1;
                if (b == abort_blk) begin
                    budget = 0;
                    while (dbg_state != WAIT_DONE && budget < 50) begin
                        @(posedge clk); #1;
                        budget++;
                    end
                    chk("reach_wait_done", dbg_state, WAIT_DONE);
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    chk("abort_state", dbg_state, IDLE);
                    chk("abort_busy", busy, 0);
                    chk("abort_block", core_block, 0);
                    repeat (15) @(posedge clk);
                    #1;
                    chk("abort_no_done", done_cnt, d0);
                    chk("abort_idle", dbg_state, IDLE);
                    return;
                end
            end
        end
        budget = 0;
        while (done_cnt == d0 && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        mif.msg_valid = 1'b0;
        mif.msg_data  = '0;
        mif.msg_last  = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {core_init, core_next, busy, done, err, mif.msg_ready}, 0);
        chk("reset_block", core_block, 0);
        chk("reset_state", dbg_state, IDLE);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_state", dbg_state, IDLE);

        // Single counting block.
        send_msg(1, -1, -1, -1, 1'b0, 1'b1);
        // Three random blocks with stream gaps.
        send_msg(3, -1, -1, -1, 1'b1, 1'b0);
        // Premature msg_last, then a clean message that clears err.
        send_msg(1, 10, -1, -1, 1'b0, 1'b0);
        send_msg(1, -1, -1, -1, 1'b0, 1'b0);
        // Abort in WAIT_DONE of block 2 of 3, then a fresh message.
        send_msg(3, -1, -1, 1, 1'b0, 1'b0);
        send_msg(1, -1, -1, -1, 1'b1, 1'b0);
        // Random mix with gaps.
        for (int k = 0; k < 4; k++) send_msg($urandom_range(1, 3), -1, -1, -1, 1'b1, 1'b0);
        // Reset while in CMD, reset in FILL at word 17, then the counting block.
        send_msg(1, -1, 31, -1, 1'b0, 1'b1);
        send_msg(1, -1, 17, -1, 1'b1, 1'b0);
        send_msg(1, -1, -1, -1, 1'b0, 1'b1);

        repeat (20) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
